h_maq_stream: RTL

- Consumer side of the quantized cell-state path. Takes the 8-bit quantized cell state Ct and the 8-bit output-gate sigmoid value o for each element.
- Requantizes Ct into the tanh-input domain and issues it to an external tanh LUT over a request/response handshake. Combines the LUT result with o to produce the quantized hidden state Ht.
- Streams one vector of VEC_LEN elements at a time between the cell-state update stage and the Ht buffer.

---
 rtl/h_maq_pkg.sv | 28 ++
 rtl/h_maq_stream_if.sv | 28 ++
 rtl/h_maq_requant.sv | 42 ++++
 rtl/h_maq_stream.sv | 129 ++++++++++++
 4 files changed

// File: rtl/h_maq_pkg.sv
// Shared types and helpers for the Ht output stage.
package h_maq_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] CALC = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_WAIT = WAIT,
        ST_CALC = CALC,
        ST_OUT  = OUT
    } state_t;

    // Clamp a signed intermediate into the unsigned 8-bit quantized range.
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/h_maq_stream_if.sv
// Element, tanh LUT and Ht handshakes of the Ht output stage.
// master: the Ht stage itself; slave: its environment (Ct source, LUT, Ht sink).
interface h_maq_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_ct;
    logic [7:0] in_o;
    logic       tanh_req_valid;
    logic       tanh_req_ready;
    logic [7:0] tanh_req_data;
    logic       tanh_rsp_valid;
    logic [7:0] tanh_rsp_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_h;
    logic       out_last;
    logic       busy;

    modport master (
        input  in_valid, in_ct, in_o, tanh_req_ready, tanh_rsp_valid, tanh_rsp_data, out_ready,
        output in_ready, tanh_req_valid, tanh_req_data, out_valid, out_h, out_last, busy
    );

    modport slave (
        output in_valid, in_ct, in_o, tanh_req_ready, tanh_rsp_valid, tanh_rsp_data, out_ready,
        input  in_ready, tanh_req_valid, tanh_req_data, out_valid, out_h, out_last, busy
    );
endinterface

// File: rtl/h_maq_requant.sv
// Combinational requantization: Ct -> tanh input, and (o, tanh) -> Ht.
module h_maq_requant
    import h_maq_pkg::*;
#(
    parameter logic [9:0] SCALE_DATA        = 10'd128,
    parameter logic [9:0] SCALE_STATE       = 10'd128,
    parameter logic [9:0] SCALE_TANH        = 10'd48,
    parameter logic [7:0] ZERO_DATA         = 8'd128,
    parameter logic [7:0] ZERO_STATE        = 8'd128,
    parameter logic [7:0] ZERO_TANH         = 8'd128,
    parameter logic [9:0] OUT_SCALE_SIGMOID = 10'd256,
    parameter logic [9:0] OUT_SCALE_TANH    = 10'd128,
    parameter logic [7:0] OUT_ZERO_SIGMOID  = 8'd0,
    parameter logic [7:0] OUT_ZERO_TANH     = 8'd128
) (
    input  logic [7:0] ct,
    input  logic [7:0] o,
    input  logic [7:0] t,
    output logic [7:0] tq,
    output logic [7:0] h
);
    localparam int K_SD  = int'(SCALE_DATA);
    localparam int K_SS  = int'(SCALE_STATE);
    localparam int K_ST  = int'(SCALE_TANH);
    localparam int K_ZD  = int'(ZERO_DATA);
    localparam int K_ZS  = int'(ZERO_STATE);
    localparam int K_ZT  = int'(ZERO_TANH);
    localparam int K_OSS = int'(OUT_SCALE_SIGMOID);
    localparam int K_OST = int'(OUT_SCALE_TANH);
    localparam int K_OZS = int'(OUT_ZERO_SIGMOID);
    localparam int K_OZT = int'(OUT_ZERO_TANH);

    // Signed int arithmetic so the divides truncate toward zero.
    int tq_raw;
    int h_raw;

    assign tq_raw = ((int'(ct) - K_ZS) * K_ST) / K_SS + K_ZT;
    assign h_raw  = ((int'(o) - K_OZS) * (int'(t) - K_OZT) * K_SD) / (K_OSS * K_OST) + K_ZD;

    assign tq = sat8(tq_raw);
    assign h  = sat8(h_raw);
endmodule

// File: rtl/h_maq_stream.sv
// Ht output stage: one element in flight at a time through the tanh LUT.
//
//  state | meaning
//  IDLE  | ready for the next Ct/o element
//  REQ   | tanh request presented, waiting for LUT acceptance
//  WAIT  | waiting for the LUT response
//  CALC  | computing and registering Ht and the last flag
//  OUT   | Ht presented, waiting for downstream acceptance
module h_maq_stream
    import h_maq_pkg::*;
#(
    parameter logic [9:0] SCALE_DATA        = 10'd128,
    parameter logic [9:0] SCALE_STATE       = 10'd128,
    parameter logic [9:0] SCALE_TANH        = 10'd48,
    parameter logic [7:0] ZERO_DATA         = 8'd128,
    parameter logic [7:0] ZERO_STATE        = 8'd128,
    parameter logic [7:0] ZERO_TANH         = 8'd128,
    parameter logic [9:0] OUT_SCALE_SIGMOID = 10'd256,
    parameter logic [9:0] OUT_SCALE_TANH    = 10'd128,
    parameter logic [7:0] OUT_ZERO_SIGMOID  = 8'd0,
    parameter logic [7:0] OUT_ZERO_TANH     = 8'd128,
    parameter int         VEC_LEN           = 16
) (
    input  logic           clk,
    input  logic           rstn,
    h_maq_stream_if.master bus
);
    localparam int              CW       = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(VEC_LEN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    o_q;
    logic [7:0]    t_q;
    logic [7:0]    tq_q;
    logic [7:0]    h_q;
    logic          last_q;
    logic [7:0]    tq_c;
    logic [7:0]    h_c;

    // tq is taken straight from the input so it can be registered on acceptance.
    h_maq_requant #(
        .SCALE_DATA       (SCALE_DATA),
        .SCALE_STATE      (SCALE_STATE),
        .SCALE_TANH       (SCALE_TANH),
        .ZERO_DATA        (ZERO_DATA),
        .ZERO_STATE       (ZERO_STATE),
        .ZERO_TANH        (ZERO_TANH),
        .OUT_SCALE_SIGMOID(OUT_SCALE_SIGMOID),
        .OUT_SCALE_TANH   (OUT_SCALE_TANH),
        .OUT_ZERO_SIGMOID (OUT_ZERO_SIGMOID),
        .OUT_ZERO_TANH    (OUT_ZERO_TANH)
    ) u_requant (
        .ct(bus.in_ct),
        .o (o_q),
        .t (t_q),
        .tq(tq_c),
        .h (h_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt          = state;
        bus.in_ready       = 1'b0;
        bus.tanh_req_valid = 1'b0;
        bus.out_valid      = 1'b0;
        bus.busy           = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                bus.tanh_req_valid = 1'b1;
                if (bus.tanh_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.tanh_rsp_valid) state_nxt = ST_CALC;
            end
            ST_CALC: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers and element counter; each captures only in its own state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            o_q    <= '0;
            t_q    <= '0;
            tq_q   <= '0;
            h_q    <= '0;
            last_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.in_valid) begin
                    tq_q <= tq_c;
                    o_q  <= bus.in_o;
                end
                ST_WAIT: if (bus.tanh_rsp_valid) t_q <= bus.tanh_rsp_data;
                ST_CALC: begin
                    h_q    <= h_c;
                    last_q <= (cnt == LAST_IDX);
                end
                ST_OUT: if (bus.out_ready) cnt <= (cnt == LAST_IDX) ? '0 : cnt + CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.tanh_req_data = tq_q;
    assign bus.out_h         = h_q;
    assign bus.out_last      = last_q;
endmodule
